// File: rtl/ddr_ctrl_pkg.sv
// Shared DDR controller definitions: command encodings and timing parameter widths.
package ddr_ctrl_pkg;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_NOP = 3'd0;
    localparam cmd_t CMD_ACT = 3'd1;
    localparam cmd_t CMD_RD  = 3'd2;
    localparam cmd_t CMD_WR  = 3'd3;
    localparam cmd_t CMD_PRE = 3'd4;
    localparam cmd_t CMD_REF = 3'd5;

    localparam int TBANK_W = 8;
    localparam int TGLB_W  = 4;
    localparam int TFAW_W  = 6;
    localparam int TREF_W  = 16;

endpackage

// File: rtl/timing_down_counter.sv
// Saturating down-counter for one spacing rule: loads T-1 on issue and flags
// zero once the follow-on command becomes legal.
module timing_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] t_val,
    output logic         zero
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = (t_val == '0) ? '0 : t_val - W'(1);
        end else if (value_q != '0) begin
            value_d = value_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign zero = (value_q == '0);

endmodule

// File: rtl/cmd_timing_enforcer.sv
// Holds scheduler commands until every bank/global spacing rule is met, then
// issues them to the PHY one clock later; also tracks the refresh interval.
module cmd_timing_enforcer
    import ddr_ctrl_pkg::*;
#(
    parameter int NUM_BANKS = 8,
    parameter int BANK_W    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [TBANK_W-1:0]   tRC,
    input  logic [TBANK_W-1:0]   tRAS,
    input  logic [TBANK_W-1:0]   tRP,
    input  logic [TBANK_W-1:0]   tRCD,
    input  logic [TBANK_W-1:0]   tWR,
    input  logic [TGLB_W-1:0]    tRRD,
    input  logic [TGLB_W-1:0]    tWTR,
    input  logic [TGLB_W-1:0]    tCCD,
    input  logic [TFAW_W-1:0]    tFAW,
    input  logic [TREF_W-1:0]    tREFI,
    input  logic [TREF_W-1:0]    tRFC,
    input  logic                 req_valid,
    input  logic [2:0]           req_cmd,
    input  logic [BANK_W-1:0]    req_bank,
    output logic                 req_ready,
    output logic                 cmd_valid,
    output logic [2:0]           cmd_code,
    output logic [BANK_W-1:0]    cmd_bank,
    output logic [NUM_BANKS-1:0] bank_open,
    output logic                 ref_due
);

    logic                 issue, act_issue, rd_issue, wr_issue, pre_issue, ref_issue;
    logic                 pre_load, b_open;
    logic [NUM_BANKS-1:0] rc_zero, rcd_zero, ras_zero, rp_zero, wr_zero;
    logic                 rrd_zero, ccd_zero, wtr_zero, rfc_zero, faw_ok;
    logic [3:0]           faw_zero, faw_load;

    logic [NUM_BANKS-1:0] bank_open_q, bank_open_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic [2:0]           cmd_code_q, cmd_code_d;
    logic [BANK_W-1:0]    cmd_bank_q, cmd_bank_d;
    logic [TREF_W-1:0]    ref_cnt_q, ref_cnt_d;
    logic                 ref_due_q, ref_due_d;

    assign b_open    = bank_open_q[req_bank];
    assign issue     = req_valid && req_ready && (req_cmd != CMD_NOP);
    assign act_issue = issue && (req_cmd == CMD_ACT);
    assign rd_issue  = issue && (req_cmd == CMD_RD);
    assign wr_issue  = issue && (req_cmd == CMD_WR);
    assign pre_issue = issue && (req_cmd == CMD_PRE);
    assign ref_issue = issue && (req_cmd == CMD_REF);
    // A PRE to an already closed bank is a no-op for timing purposes.
    assign pre_load  = pre_issue && b_open;

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        logic hit;
        assign hit = (req_bank == BANK_W'(i));

        timing_down_counter #(.W(TBANK_W)) u_rc  (.clk(clk), .reset(reset), .load(act_issue && hit), .t_val(tRC),  .zero(rc_zero[i]));
        timing_down_counter #(.W(TBANK_W)) u_rcd (.clk(clk), .reset(reset), .load(act_issue && hit), .t_val(tRCD), .zero(rcd_zero[i]));
        timing_down_counter #(.W(TBANK_W)) u_ras (.clk(clk), .reset(reset), .load(act_issue && hit), .t_val(tRAS), .zero(ras_zero[i]));
        timing_down_counter #(.W(TBANK_W)) u_rp  (.clk(clk), .reset(reset), .load(pre_load && hit),  .t_val(tRP),  .zero(rp_zero[i]));
        timing_down_counter #(.W(TBANK_W)) u_wr  (.clk(clk), .reset(reset), .load(wr_issue && hit),  .t_val(tWR),  .zero(wr_zero[i]));
    end

    timing_down_counter #(.W(TGLB_W)) u_rrd (.clk(clk), .reset(reset), .load(act_issue),            .t_val(tRRD), .zero(rrd_zero));
    timing_down_counter #(.W(TGLB_W)) u_ccd (.clk(clk), .reset(reset), .load(rd_issue || wr_issue), .t_val(tCCD), .zero(ccd_zero));
    timing_down_counter #(.W(TGLB_W)) u_wtr (.clk(clk), .reset(reset), .load(wr_issue),             .t_val(tWTR), .zero(wtr_zero));
    timing_down_counter #(.W(TREF_W)) u_rfc (.clk(clk), .reset(reset), .load(ref_issue),            .t_val(tRFC), .zero(rfc_zero));

    for (genvar s = 0; s < 4; s++) begin : g_faw
        timing_down_counter #(.W(TFAW_W)) u_faw (.clk(clk), .reset(reset), .load(faw_load[s]), .t_val(tFAW), .zero(faw_zero[s]));
    end

    assign faw_ok = |faw_zero;

    // Each ACT claims the lowest idle window slot so a running window is never overwritten.
    always_comb begin
        faw_load = '0;
        if (act_issue) begin
            if (faw_zero[0])      faw_load[0] = 1'b1;
            else if (faw_zero[1]) faw_load[1] = 1'b1;
            else if (faw_zero[2]) faw_load[2] = 1'b1;
            else if (faw_zero[3]) faw_load[3] = 1'b1;
        end
    end

    always_comb begin
        req_ready = 1'b0;
        if (!reset) begin
            case (req_cmd)
                CMD_NOP: req_ready = 1'b1;
                CMD_ACT: req_ready = !b_open && rc_zero[req_bank] && rp_zero[req_bank]
                                     && rrd_zero && faw_ok && rfc_zero;
                CMD_RD:  req_ready = b_open && rcd_zero[req_bank] && ccd_zero && wtr_zero && rfc_zero;
                CMD_WR:  req_ready = b_open && rcd_zero[req_bank] && ccd_zero && rfc_zero;
                CMD_PRE: req_ready = rfc_zero && (!b_open || (ras_zero[req_bank] && wr_zero[req_bank]));
                CMD_REF: req_ready = (bank_open_q == '0) && rfc_zero;
                default: req_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        bank_open_d = bank_open_q;
        if (act_issue) bank_open_d[req_bank] = 1'b1;
        if (pre_issue) bank_open_d[req_bank] = 1'b0;

        cmd_valid_d = issue;
        cmd_code_d  = issue ? req_cmd : CMD_NOP;
        cmd_bank_d  = issue ? req_bank : '0;
    end

    // The interval counter saturates at tREFI and leaves ref_due pending until a REF goes out.
    always_comb begin
        ref_cnt_d = ref_cnt_q;
        ref_due_d = ref_due_q;
        if (ref_issue) begin
            ref_cnt_d = '0;
            ref_due_d = 1'b0;
        end else if (tREFI == '0) begin
            ref_cnt_d = '0;
        end else begin
            if (ref_cnt_q < tREFI) ref_cnt_d = ref_cnt_q + TREF_W'(1);
            if (ref_cnt_d >= tREFI) ref_due_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_open_q <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= CMD_NOP;
            cmd_bank_q  <= '0;
            ref_cnt_q   <= '0;
            ref_due_q   <= 1'b0;
        end else begin
            bank_open_q <= bank_open_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_bank_q  <= cmd_bank_d;
            ref_cnt_q   <= ref_cnt_d;
            ref_due_q   <= ref_due_d;
        end
    end

    assign bank_open = bank_open_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_bank  = cmd_bank_q;
    assign ref_due   = ref_due_q;

endmodule

// File: tb/tb_cmd_timing_enforcer.sv
// Directed bench for cmd_timing_enforcer: a per-cycle vector table plus
// hand-written sequences for tFAW, refresh and mid-count reset.
module tb_cmd_timing_enforcer;
    import ddr_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  tRC, tRAS, tRP, tRCD, tWR;
    logic [3:0]  tRRD, tWTR, tCCD;
    logic [5:0]  tFAW;
    logic [15:0] tREFI, tRFC;
    logic        req_valid;
    logic [2:0]  req_cmd;
    logic [2:0]  req_bank;
    logic        req_ready;
    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic [2:0]  cmd_bank;
    logic [7:0]  bank_open;
    logic        ref_due;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [2:0] cmd;
        logic [2:0] bank;
        logic       rdy;
        logic       cv;
        logic [2:0] code;
        logic [2:0] cbank;
        logic [7:0] open;
    } vec_t;

    vec_t vecs[24];

    always #5 clk = ~clk;

    cmd_timing_enforcer #(.NUM_BANKS(8), .BANK_W(3)) dut (
        .clk(clk), .reset(reset),
        .tRC(tRC), .tRAS(tRAS), .tRP(tRP), .tRCD(tRCD), .tWR(tWR),
        .tRRD(tRRD), .tWTR(tWTR), .tCCD(tCCD), .tFAW(tFAW),
        .tREFI(tREFI), .tRFC(tRFC),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_bank(req_bank),
        .req_ready(req_ready), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_bank(cmd_bank), .bank_open(bank_open), .ref_due(ref_due)
    );

    function automatic vec_t mk(input logic [2:0] cmd, input logic [2:0] bank, input logic rdy,
                                input logic cv, input logic [2:0] code, input logic [2:0] cbank,
                                input logic [7:0] open);
        vec_t v;
        v.cmd = cmd; v.bank = bank; v.rdy = rdy; v.cv = cv;
        v.code = code; v.cbank = cbank; v.open = open;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] c, input logic [2:0] b);
        req_valid = v;
        req_cmd   = c;
        req_bank  = b;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearTimings();
        tRC = 8'd0; tRAS = 8'd0; tRP = 8'd0; tRCD = 8'd0; tWR = 8'd0;
        tRRD = 4'd0; tWTR = 4'd0; tCCD = 4'd0; tFAW = 6'd0;
        tREFI = 16'd0; tRFC = 16'd0;
    endtask

    // Leaves the bench 1 time unit into cycle 0, the first cycle out of reset.
    task automatic resetDut();
        @(posedge clk);
        #1;
        reset = 1'b1;
        req_valid = 1'b0; req_cmd = CMD_NOP; req_bank = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int  issue_at[5];
        int  acts;
        logic exp_rdy;

        reset = 1'b1;
        req_valid = 1'b0; req_cmd = CMD_NOP; req_bank = 3'd0;
        clearTimings();

        vecs[0]  = mk(CMD_ACT, 3'd0, 1'b1, 1'b0, CMD_NOP, 3'd0, 8'h00);
        vecs[1]  = mk(CMD_RD,  3'd0, 1'b0, 1'b1, CMD_ACT, 3'd0, 8'h01);
        vecs[2]  = mk(CMD_RD,  3'd0, 1'b0, 1'b0, CMD_NOP, 3'd0, 8'h01);
        vecs[3]  = mk(CMD_RD,  3'd0, 1'b0, 1'b0, CMD_NOP, 3'd0, 8'h01);
        vecs[4]  = mk(CMD_RD,  3'd0, 1'b0, 1'b0, CMD_NOP, 3'd0, 8'h01);
        vecs[5]  = mk(CMD_RD,  3'd0, 1'b1, 1'b0, CMD_NOP, 3'd0, 8'h01);
        vecs[6]  = mk(CMD_NOP, 3'd0, 1'b1, 1'b1, CMD_RD,  3'd0, 8'h01);
        vecs[7]  = mk(CMD_RD,  3'd2, 1'b0, 1'b0, CMD_NOP, 3'd0, 8'h01);
        vecs[8]  = mk(CMD_ACT, 3'd0, 1'b0, 1'b0, CMD_NOP, 3'd0, 8'h01);
        vecs[9]  = mk(3'd6,    3'd0, 1'b0, 1'b0, CMD_NOP, 3'd0, 8'h01);
        vecs[10] = mk(3'd7,    3'd1, 1'b0, 1'b0, CMD_NOP, 3'd0, 8'h01);
        vecs[11] = mk(CMD_ACT, 3'd3, 1'b1, 1'b0, CMD_NOP, 3'd0, 8'h01);
        vecs[12] = mk(CMD_WR,  3'd3, 1'b0, 1'b1, CMD_ACT, 3'd3, 8'h09);
        vecs[13] = mk(CMD_WR,  3'd3, 1'b0, 1'b0, CMD_NOP, 3'd0, 8'h09);
        vecs[14] = mk(CMD_WR,  3'd3, 1'b0, 1'b0, CMD_NOP, 3'd0, 8'h09);
        vecs[15] = mk(CMD_WR,  3'd3, 1'b0, 1'b0, CMD_NOP, 3'd0, 8'h09);
        vecs[16] = mk(CMD_WR,  3'd3, 1'b1, 1'b0, CMD_NOP, 3'd0, 8'h09);
        vecs[17] = mk(CMD_RD,  3'd0, 1'b0, 1'b1, CMD_WR,  3'd3, 8'h09);
        vecs[18] = mk(CMD_RD,  3'd0, 1'b0, 1'b0, CMD_NOP, 3'd0, 8'h09);
        vecs[19] = mk(CMD_RD,  3'd0, 1'b1, 1'b0, CMD_NOP, 3'd0, 8'h09);
        vecs[20] = mk(CMD_PRE, 3'd3, 1'b0, 1'b1, CMD_RD,  3'd0, 8'h09);
        vecs[21] = mk(CMD_PRE, 3'd3, 1'b0, 1'b0, CMD_NOP, 3'd0, 8'h09);
        vecs[22] = mk(CMD_PRE, 3'd3, 1'b1, 1'b0, CMD_NOP, 3'd0, 8'h09);
        vecs[23] = mk(CMD_NOP, 3'd0, 1'b1, 1'b1, CMD_PRE, 3'd3, 8'h01);

        // tRCD, state legality, tWTR and tWR via the vector table
        clearTimings();
        tRCD = 8'd5; tWR = 8'd6; tWTR = 4'd3;
        resetDut();
        checkOutput("reset cmd_valid", 32'(cmd_valid), 32'd0);
        checkOutput("reset bank_open", 32'(bank_open), 32'd0);
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, vecs[i].cmd, vecs[i].bank);
            checkOutput($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vecs[i].rdy));
            checkOutput($sformatf("vec%0d cmd_valid", i), 32'(cmd_valid), 32'(vecs[i].cv));
            checkOutput($sformatf("vec%0d cmd_code", i), 32'(cmd_code), 32'(vecs[i].code));
            checkOutput($sformatf("vec%0d bank_open", i), 32'(bank_open), 32'(vecs[i].open));
            if (vecs[i].cv) checkOutput($sformatf("vec%0d cmd_bank", i), 32'(cmd_bank), 32'(vecs[i].cbank));
            tick();
        end
        checkOutput("tREFI=0 ref_due", 32'(ref_due), 32'd0);

        // tFAW: ACT b0..b3 at tRRD spacing, fifth ACT waits for the window
        clearTimings();
        tRRD = 4'd4; tFAW = 6'd20;
        resetDut();
        issue_at[0] = 0; issue_at[1] = 4; issue_at[2] = 8; issue_at[3] = 12; issue_at[4] = 20;
        acts = 0;
        for (int cyc = 0; cyc <= 21; cyc++) begin
            applyStimulus(acts < 5, CMD_ACT, 3'(acts));
            exp_rdy = 1'b0;
            if (acts < 5) exp_rdy = (cyc == issue_at[acts]);
            if (acts < 5) checkOutput($sformatf("faw c%0d ready", cyc), 32'(req_ready), 32'(exp_rdy));
            if (exp_rdy) acts++;
            if (cyc == 21) begin
                checkOutput("faw 5th cmd_valid", 32'(cmd_valid), 32'd1);
                checkOutput("faw 5th cmd_bank", 32'(cmd_bank), 32'd4);
                checkOutput("faw bank_open", 32'(bank_open), 32'h1f);
            end
            tick();
        end

        // Refresh: ref_due at tREFI, REF then tRFC blocking (tRFC changed mid-count)
        clearTimings();
        tREFI = 16'd100; tRFC = 16'd30;
        resetDut();
        for (int cyc = 0; cyc <= 101; cyc++) begin
            applyStimulus(1'b1, CMD_NOP, 3'd0);
            if (cyc == 99)  checkOutput("ref_due c99", 32'(ref_due), 32'd0);
            if (cyc == 100) checkOutput("ref_due c100", 32'(ref_due), 32'd1);
            tick();
        end
        applyStimulus(1'b1, CMD_REF, 3'd0);
        checkOutput("REF ready c102", 32'(req_ready), 32'd1);
        checkOutput("ref_due c102", 32'(ref_due), 32'd1);
        tick();
        for (int cyc = 103; cyc <= 132; cyc++) begin
            if (cyc == 110) tRFC = 16'd0;
            applyStimulus(1'b1, CMD_ACT, 3'd0);
            if (cyc == 103) begin
                checkOutput("ref_due cleared", 32'(ref_due), 32'd0);
                checkOutput("REF cmd_valid", 32'(cmd_valid), 32'd1);
                checkOutput("REF cmd_code", 32'(cmd_code), 32'(CMD_REF));
            end
            checkOutput($sformatf("tRFC c%0d ready", cyc), 32'(req_ready), 32'(cyc >= 132));
            tick();
        end

        // Reset in the middle of a tRC count
        clearTimings();
        tRC = 8'd40;
        resetDut();
        applyStimulus(1'b1, CMD_ACT, 3'd5);
        checkOutput("rst-case ACT ready", 32'(req_ready), 32'd1);
        tick();
        applyStimulus(1'b1, CMD_ACT, 3'd5);
        checkOutput("rst-case open ready", 32'(req_ready), 32'd0);
        checkOutput("rst-case cmd_bank", 32'(cmd_bank), 32'd5);
        checkOutput("rst-case bank_open", 32'(bank_open), 32'h20);
        tick();
        tick();
        reset = 1'b1;
        applyStimulus(1'b1, CMD_NOP, 3'd5);
        checkOutput("ready during reset", 32'(req_ready), 32'd0);
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, CMD_ACT, 3'd5);
        checkOutput("post-reset cmd_valid", 32'(cmd_valid), 32'd0);
        checkOutput("post-reset cmd_code", 32'(cmd_code), 32'd0);
        checkOutput("post-reset cmd_bank", 32'(cmd_bank), 32'd0);
        checkOutput("post-reset bank_open", 32'(bank_open), 32'd0);
        checkOutput("post-reset ref_due", 32'(ref_due), 32'd0);
        checkOutput("post-reset ACT ready", 32'(req_ready), 32'd1);
        tick();
        applyStimulus(1'b0, CMD_NOP, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
